// File: rtl/sd_block_streamer_if.sv
// rtl/sd_block_streamer_if.sv - SD reader register bus plus output word stream for sd_block_streamer
//
// Signals
//   sd_address    reader register select: 0 = address/data, 1 = status
//   sd_write      one-cycle write strobe
//   sd_writedata  block address written to the reader
//   sd_read       one-cycle read strobe
//   sd_readdata   reader read data, valid in the same cycle as sd_read
//   out_data      stream word
//   out_valid     out_data holds a word
//   out_ready     consumer accepts the word when high together with out_valid
//   out_eob       last word of a block
//   out_last      last word of the transfer
// Modports
//   master        streamer side: drives the reader strobes and the stream
//   slave         reader/consumer side
interface sd_block_streamer_if;
    logic        sd_address;
    logic        sd_write;
    logic [31:0] sd_writedata;
    logic        sd_read;
    logic [31:0] sd_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_eob;
    logic        out_last;

    modport master (
        output sd_address, sd_write, sd_writedata, sd_read,
        input  sd_readdata,
        output out_data, out_valid, out_eob, out_last,
        input  out_ready
    );

    modport slave (
        input  sd_address, sd_write, sd_writedata, sd_read,
        output sd_readdata,
        input  out_data, out_valid, out_eob, out_last,
        output out_ready
    );
endinterface

// File: rtl/sd_block_streamer.sv
// rtl/sd_block_streamer.sv - multi-block SD read sequencer producing a valid/ready word stream
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, ignored while a transfer is running
//   start_block  first block address, sampled on an accepted start
//   num_blocks   blocks to read, sampled on an accepted start (0 = immediate done)
//   bus          reader register bus and output stream (sd_block_streamer_if.master)
//   busy         transfer in progress
//   done         one-cycle pulse on successful completion
//   error        sticky abort flag, cleared by the next accepted start
//   err_code     {timeout, crc, cmd} status bits of the last failure (0 = data underrun)
module sd_block_streamer #(
    parameter int ADDR_STEP = 1,
    parameter int MAX_RETRY = 2,
    parameter int SETTLE    = 4,
    parameter int READ_GAP  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [31:0]                 start_block,
    input  logic [15:0]                 num_blocks,
    sd_block_streamer_if.master         bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [2:0]                  err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_POLL, S_FETCH,
        S_READ, S_HOLD, S_GAP, S_NEXT, S_FAIL
    } state_t;

    // Wait states count down to zero inclusive, so load N-1 for N idle cycles.
    localparam logic [15:0] SETTLE_LOAD = (SETTLE > 1)   ? 16'(SETTLE - 1)   : 16'd0;
    localparam logic [15:0] GAP_LOAD    = (READ_GAP > 1) ? 16'(READ_GAP - 1) : 16'd0;
    localparam logic [31:0] STEP        = 32'(ADDR_STEP);
    localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] blocks_q, blocks_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sd_address_q, sd_address_d;
    logic        sd_write_q, sd_write_d;
    logic [31:0] sd_writedata_q, sd_writedata_d;
    logic        sd_read_q, sd_read_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_eob_q, out_eob_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  err_code_q, err_code_d;

    // Every bus access takes two cycles in its state: a setup cycle that
    // drives sd_address and raises the registered strobe, then the strobe
    // cycle in which sd_readdata is sampled and the strobe drops. This keeps
    // the address settled before the strobe and guarantees strobes never
    // run back to back.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        blocks_d       = blocks_q;
        retry_d        = retry_q;
        wcnt_d         = wcnt_q;
        cnt_d          = cnt_q;
        sd_address_d   = sd_address_q;
        sd_write_d     = 1'b0;
        sd_writedata_d = 32'd0;
        sd_read_d      = 1'b0;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_eob_d      = out_eob_q;
        out_last_d     = out_last_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = error_q;
        err_code_d     = err_code_q;

        case (state_q)
            S_IDLE: begin
                // done_q high means a transfer just finished; a start landing
                // on that cycle is dropped.
                if (start && !done_q) begin
                    error_d    = 1'b0;
                    err_code_d = 3'd0;
                    if (num_blocks != 16'd0) begin
                        addr_d   = start_block;
                        blocks_d = num_blocks;
                        retry_d  = 8'd0;
                        busy_d   = 1'b1;
                        state_d  = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                sd_address_d   = 1'b0;
                sd_writedata_d = addr_q;
                if (!sd_write_q) begin
                    sd_write_d = 1'b1;
                end else begin
                    sd_writedata_d = 32'd0;
                    cnt_d          = SETTLE_LOAD;
                    state_d        = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_POLL;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            S_POLL: begin
                sd_address_d = 1'b1;
                if (!sd_read_q) begin
                    sd_read_d = 1'b1;
                end else if (bus.sd_readdata[0]) begin
                    // Reader still busy: one idle cycle, then poll again.
                    cnt_d   = 16'd0;
                    state_d = S_SETTLE;
                end else if (|bus.sd_readdata[4:2]) begin
                    err_code_d = bus.sd_readdata[4:2];
                    state_d    = S_FAIL;
                end else begin
                    wcnt_d  = 8'd0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                sd_address_d = 1'b1;
                if (!sd_read_q) begin
                    sd_read_d = 1'b1;
                end else if (!bus.sd_readdata[1]) begin
                    // Reader ran dry before the block was complete.
                    err_code_d = 3'd0;
                    state_d    = S_FAIL;
                end else begin
                    state_d = S_READ;
                end
            end

            S_READ: begin
                sd_address_d = 1'b0;
                if (!sd_read_q) begin
                    sd_read_d = 1'b1;
                end else begin
                    out_data_d  = bus.sd_readdata;
                    out_valid_d = 1'b1;
                    out_eob_d   = (wcnt_q == 8'd127);
                    out_last_d  = (wcnt_q == 8'd127) && (blocks_q == 16'd1);
                    state_d     = S_HOLD;
                end
            end

            S_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_eob_d   = 1'b0;
                    out_last_d  = 1'b0;
                    wcnt_d      = wcnt_q + 8'd1;
                    cnt_d       = GAP_LOAD;
                    state_d     = S_GAP;
                end
            end

            S_GAP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (wcnt_q == 8'd128) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_NEXT: begin
                blocks_d = blocks_q - 16'd1;
                addr_d   = addr_q + STEP;
                retry_d  = 8'd0;
                if (blocks_q == 16'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_FAIL: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 8'd1;
                    state_d = S_ISSUE;
                end else begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            addr_q         <= 32'd0;
            blocks_q       <= 16'd0;
            retry_q        <= 8'd0;
            wcnt_q         <= 8'd0;
            cnt_q          <= 16'd0;
            sd_address_q   <= 1'b0;
            sd_write_q     <= 1'b0;
            sd_writedata_q <= 32'd0;
            sd_read_q      <= 1'b0;
            out_data_q     <= 32'd0;
            out_valid_q    <= 1'b0;
            out_eob_q      <= 1'b0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            err_code_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            blocks_q       <= blocks_d;
            retry_q        <= retry_d;
            wcnt_q         <= wcnt_d;
            cnt_q          <= cnt_d;
            sd_address_q   <= sd_address_d;
            sd_write_q     <= sd_write_d;
            sd_writedata_q <= sd_writedata_d;
            sd_read_q      <= sd_read_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_eob_q      <= out_eob_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
        end
    end

    assign bus.sd_address   = sd_address_q;
    assign bus.sd_write     = sd_write_q;
    assign bus.sd_writedata = sd_writedata_q;
    assign bus.sd_read      = sd_read_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_eob      = out_eob_q;
    assign bus.out_last     = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign err_code         = err_code_q;

endmodule

// File: tb/tb_sd_block_streamer.sv
// tb/tb_sd_block_streamer.sv - directed self-checking bench for sd_block_streamer with an SD reader model
module tb_sd_block_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] start_block;
    logic [15:0] num_blocks;
    logic        busy, done, error;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    sd_block_streamer_if ifc();

    sd_block_streamer #(
        .ADDR_STEP(512), .MAX_RETRY(2), .SETTLE(4), .READ_GAP(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .start_block(start_block), .num_blocks(num_blocks),
        .bus(ifc), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    // Reader model: an address write starts a block; status shows busy for a
    // few cycles, then either injected error bits or data_valid while words
    // remain. Word value = word_base + 128 * block_index + position, where
    // block_index counts ADDR_STEP (512) strides from xfer_base.
    int          fail_mode = 0;   // 0 clean, 1 crc on first attempt, 2 timeout always
    int          wr_snap   = 0;
    logic [31:0] word_base = 32'd0;
    logic [31:0] xfer_base = 32'd0;

    logic [31:0] m_addr;
    int          m_busy_cnt, m_ptr;
    int          m_wr_total = 0;
    logic        m_active;
    logic        fail_now;
    logic [31:0] status_word, data_word;

    assign fail_now  = (fail_mode == 2) || (fail_mode == 1 && (m_wr_total - wr_snap) == 1);
    assign data_word = word_base + (((m_addr - xfer_base) >> 9) << 7) + 32'(m_ptr);

    always_comb begin
        status_word = 32'd0;
        if (m_busy_cnt != 0)                status_word[0] = 1'b1;
        else if (fail_now && fail_mode == 1) status_word[3] = 1'b1;
        else if (fail_now)                   status_word[4] = 1'b1;
        else if (m_active && m_ptr < 128)    status_word[1] = 1'b1;
    end

    assign ifc.sd_readdata = ifc.sd_address ? status_word : data_word;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_addr     <= 32'd0;
            m_busy_cnt <= 0;
            m_ptr      <= 0;
            m_active   <= 1'b0;
        end else if (ifc.sd_write) begin
            m_addr     <= ifc.sd_writedata;
            m_busy_cnt <= 7;
            m_ptr      <= 0;
            m_active   <= 1'b1;
            m_wr_total <= m_wr_total + 1;
        end else begin
            if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
            if (ifc.sd_read && !ifc.sd_address && m_ptr < 128) m_ptr <= m_ptr + 1;
        end
    end

    // Monitor: logs accepted words, address writes, done pulses and bus-rule breaches.
    typedef struct packed {
        logic [31:0] d;
        logic        eob;
        logic        last;
    } word_t;

    word_t       acc_q[$];
    logic [31:0] wr_log[$];
    int          done_cnt = 0;
    int          viol_cnt = 0;
    logic        prev_strobe = 1'b0;

    always @(negedge clk) begin
        word_t w;
        if (ifc.out_valid && ifc.out_ready) begin
            w.d    = ifc.out_data;
            w.eob  = ifc.out_eob;
            w.last = ifc.out_last;
            acc_q.push_back(w);
        end
        if (ifc.sd_write) wr_log.push_back(ifc.sd_writedata);
        if (done) done_cnt++;
        if (ifc.sd_write && ifc.sd_read) viol_cnt++;
        if (ifc.sd_read && ifc.out_valid) viol_cnt++;
        if ((ifc.sd_read || ifc.sd_write) && prev_strobe) viol_cnt++;
        prev_strobe = ifc.sd_read || ifc.sd_write;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] blk, input logic [15:0] n);
        @(posedge clk); #1;
        start_block = blk;
        num_blocks  = n;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_words(input int target, input int budget);
        int k = 0;
        while (acc_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_stream(input string tag, input int from, input logic [31:0] base, input int total);
        chk({tag, "_nwords"}, 32'(acc_q.size() - from), 32'(total));
        for (int i = 0; i < total && from + i < acc_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), acc_q[from+i].d, base + 32'(i));
            chk($sformatf("%s_eob%0d", tag, i), 32'(acc_q[from+i].eob), 32'(i % 128 == 127));
            chk($sformatf("%s_last%0d", tag, i), 32'(acc_q[from+i].last), 32'(i == total - 1));
        end
    endtask

    task automatic prep(input int mode, input logic [31:0] blk, input logic [31:0] wbase,
                        output int ws, output int as, output int ds);
        fail_mode = mode;
        wr_snap   = m_wr_total;
        xfer_base = blk;
        word_base = wbase;
        ws = wr_log.size();
        as = acc_q.size();
        ds = done_cnt;
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, ifc.sd_address, ifc.sd_write, ifc.sd_read, ifc.out_valid,
                ifc.out_eob, ifc.out_last, busy, done, error, err_code, 2'b00};
    endfunction

    initial begin
        int ws, as, ds, stall_bad, k;
        logic [31:0] hold;

        reset_n = 1'b0;
        start = 1'b0;
        start_block = 32'd0;
        num_blocks = 16'd0;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", all_outs(), 32'd0);
        chk("rst_wdata", ifc.sd_writedata, 32'd0);
        chk("rst_odata", ifc.out_data, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single block, words 0..127.
        prep(0, 32'h100, 32'd0, ws, as, ds);
        pulse_start(32'h100, 16'd1);
        wait_idle("t1", 5000);
        chk("t1_nwr", 32'(wr_log.size() - ws), 32'd1);
        chk("t1_addr", wr_log[ws], 32'h100);
        check_stream("t1", as, 32'd0, 128);
        chk("t1_done", 32'(done_cnt - ds), 32'd1);
        chk("t1_err", 32'(error), 32'd0);

        // Three blocks with byte addressing wrapping past 2^32; a start while busy is ignored.
        prep(0, 32'hFFFF_FC00, 32'h1000, ws, as, ds);
        pulse_start(32'hFFFF_FC00, 16'd3);
        repeat (30) @(negedge clk);
        pulse_start(32'hDEAD_0000, 16'd5);
        wait_idle("t2", 20000);
        chk("t2_nwr", 32'(wr_log.size() - ws), 32'd3);
        chk("t2_addr0", wr_log[ws], 32'hFFFF_FC00);
        chk("t2_addr1", wr_log[ws+1], 32'hFFFF_FE00);
        chk("t2_addr2", wr_log[ws+2], 32'h0000_0000);
        check_stream("t2", as, 32'h1000, 384);
        chk("t2_done", 32'(done_cnt - ds), 32'd1);

        // CRC error on the first attempt, clean retry.
        prep(1, 32'h300, 32'h2000, ws, as, ds);
        pulse_start(32'h300, 16'd1);
        wait_idle("t3", 5000);
        chk("t3_nwr", 32'(wr_log.size() - ws), 32'd2);
        chk("t3_addr0", wr_log[ws], 32'h300);
        chk("t3_addr1", wr_log[ws+1], 32'h300);
        check_stream("t3", as, 32'h2000, 128);
        chk("t3_done", 32'(done_cnt - ds), 32'd1);
        chk("t3_err", 32'(error), 32'd0);

        // Timeout on every attempt: abort after the retries.
        prep(2, 32'h400, 32'h3000, ws, as, ds);
        pulse_start(32'h400, 16'd1);
        wait_idle("t4", 5000);
        chk("t4_nwr", 32'(wr_log.size() - ws), 32'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("t4_addr%0d", i), wr_log[ws+i], 32'h400);
        chk("t4_nwords", 32'(acc_q.size() - as), 32'd0);
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_code", 32'(err_code), 32'd4);
        chk("t4_done", 32'(done_cnt - ds), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Consumer stall of 50 cycles mid-block.
        prep(0, 32'h500, 32'h7000, ws, as, ds);
        pulse_start(32'h500, 16'd1);
        @(negedge clk);
        chk("t5_err_cleared", 32'(error), 32'd0);
        wait_words(as + 20, 3000);
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        k = 0;
        @(negedge clk);
        while (!ifc.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        hold = ifc.out_data;
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifc.out_data !== hold || ifc.sd_read || !ifc.out_valid) stall_bad++;
        end
        chk("t5_stall", 32'(stall_bad), 32'd0);
        chk("t5_held_word", hold, 32'h7000 + 32'd20);
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        wait_idle("t5", 5000);
        check_stream("t5", as, 32'h7000, 128);
        chk("t5_done", 32'(done_cnt - ds), 32'd1);

        // Zero-length start: immediate done, no bus activity.
        prep(0, 32'h600, 32'd0, ws, as, ds);
        pulse_start(32'h600, 16'd0);
        @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t6_pulse", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("t6_nwr", 32'(wr_log.size() - ws), 32'd0);

        // Reset in mid-block, then a fresh transfer.
        prep(0, 32'h700, 32'h9000, ws, as, ds);
        pulse_start(32'h700, 16'd2);
        wait_words(as + 10, 3000);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_flags", all_outs(), 32'd0);
        chk("t7_rst_odata", ifc.out_data, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        fail_mode = 0;
        xfer_base = 32'h40;
        word_base = 32'hA000;
        as = acc_q.size();
        pulse_start(32'h40, 16'd1);
        wait_idle("t7", 5000);
        check_stream("t7", as, 32'hA000, 128);
        chk("t7_done", 32'(done_cnt - ds), 32'd1);

        chk("bus_rules", 32'(viol_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
